// File: rtl/ysyx_22040127_mem_stage.sv
// Memory pipeline stage: holds one instruction from execute, performs its data-memory
// access over a req/rsp port, and hands the formatted result to writeback.
module ysyx_22040127_mem_stage #(
  parameter int EX_TO_MEM_WIDTH = 172,
  parameter int MEM_TO_WB_WIDTH = 102,
  parameter int ADDR_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_to_mem_valid,
  output logic                       mem_allowin,
  input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
  output logic                       mem_to_wb_valid,
  input  logic                       wb_allowin,
  output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
  output logic                       dmem_req_valid,
  input  logic                       dmem_req_ready,
  output logic                       dmem_req_wen,
  output logic [ADDR_W-1:0]          dmem_req_addr,
  output logic [63:0]                dmem_req_wdata,
  output logic [7:0]                 dmem_req_wmask,
  input  logic                       dmem_rsp_valid,
  input  logic [63:0]                dmem_rsp_rdata,
  output logic [4:0]                 mem_rd,
  output logic                       mem_load_pending
);

  localparam int JALR_BIT     = 171;
  localparam int MEMWRITE_BIT = 134;
  localparam int MEMREAD_BIT  = 133;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     state_reg, state_next;
  logic                       mem_valid_reg;
  logic [EX_TO_MEM_WIDTH-1:0] bus_reg;
  logic [63:0]                rdata_reg;

  logic [31:0] pc;
  logic [2:0]  memop;
  logic        reg_wen, memwrite, memread;
  logic [4:0]  rd;
  logic [63:0] alu_out, wdata;
  logic        unused_jalr;

  assign unused_jalr = bus_reg[JALR_BIT];
  assign pc          = bus_reg[170:139];
  assign memop       = bus_reg[138:136];
  assign reg_wen     = bus_reg[135];
  assign memwrite    = bus_reg[MEMWRITE_BIT];
  assign memread     = bus_reg[MEMREAD_BIT];
  assign rd          = bus_reg[132:128];
  assign alu_out     = bus_reg[127:64];
  assign wdata       = bus_reg[63:0];

  logic       is_mem, in_is_mem, latch, mem_ready_go;
  logic       fsm_done, rsp_capture, in_flight;
  logic [2:0] byte_off;

  assign is_mem    = memread | memwrite;
  assign in_is_mem = ex_to_mem_bus[MEMWRITE_BIT] | ex_to_mem_bus[MEMREAD_BIT];
  assign byte_off  = alu_out[2:0];

  // Handshake: the held instruction may leave and a new one enter in the same cycle.
  assign mem_ready_go    = !is_mem | fsm_done;
  assign mem_allowin     = !mem_valid_reg | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_reg & mem_ready_go;
  assign latch           = ex_to_mem_valid & mem_allowin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      mem_valid_reg <= 1'b0;
      bus_reg       <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (mem_allowin) mem_valid_reg <= ex_to_mem_valid;
      if (latch) bus_reg <= ex_to_mem_bus;
      if (rsp_capture) rdata_reg <= dmem_rsp_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_REQ:   if (dmem_req_ready) state_next = S_WAIT;
      S_WAIT:  if (dmem_rsp_valid) state_next = S_DONE;
      default: state_next = state_reg;
    endcase
    // Whenever the stage turns over, the incoming instruction decides where the FSM restarts.
    if (mem_allowin) state_next = (latch & in_is_mem) ? S_REQ : S_IDLE;
  end

  always_comb begin
    dmem_req_valid = 1'b0;
    rsp_capture    = 1'b0;
    fsm_done       = 1'b0;
    in_flight      = 1'b0;
    case (state_reg)
      S_REQ: begin
        dmem_req_valid = 1'b1;
        in_flight      = 1'b1;
      end
      S_WAIT: begin
        rsp_capture = dmem_rsp_valid;
        in_flight   = 1'b1;
      end
      S_DONE:  fsm_done = 1'b1;
      default: fsm_done = 1'b0;
    endcase
  end

  logic [3:0] size_bytes;
  always_comb begin
    case (memop[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  end

  assign dmem_req_wen   = memwrite;
  assign dmem_req_addr  = {alu_out[ADDR_W-1:3], 3'b000};
  assign dmem_req_wdata = wdata << {byte_off, 3'b000};

  // Lanes past byte 7 are simply dropped: misaligned accesses are issued as-is.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [3:0] LANE = 4'(gi);
      assign dmem_req_wmask[gi] = memwrite
                                  && (LANE >= {1'b0, byte_off})
                                  && (LANE < ({1'b0, byte_off} + size_bytes));
    end
  endgenerate

  logic [63:0] load_shifted, load_value, result;
  assign load_shifted = rdata_reg >> {byte_off, 3'b000};

  always_comb begin
    load_value = '0;
    case (memop)
      3'b000:  load_value = {{56{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_value = {{48{load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_value = {{32{load_shifted[31]}}, load_shifted[31:0]};
      3'b011:  load_value = load_shifted;
      3'b100:  load_value = {56'd0, load_shifted[7:0]};
      3'b101:  load_value = {48'd0, load_shifted[15:0]};
      3'b110:  load_value = {32'd0, load_shifted[31:0]};
      default: load_value = '0;
    endcase
  end

  logic wen_out;
  assign result           = memread ? load_value : alu_out;
  assign wen_out          = reg_wen & ~memwrite;
  assign mem_to_wb_bus    = {pc, wen_out, rd, result};
  assign mem_rd           = (mem_valid_reg & wen_out) ? rd : 5'd0;
  assign mem_load_pending = mem_valid_reg & memread & in_flight;

endmodule

// File: tb/tb_ysyx_22040127_mem_stage.sv
// Scoreboard bench for the memory stage: a driver queues expected responses at issue,
// a memory responder and a writeback monitor check the DUT independently.
`timescale 1ns/1ps
module tb_ysyx_22040127_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_to_mem_valid, mem_allowin, mem_to_wb_valid, wb_allowin;
  logic [171:0] ex_to_mem_bus;
  logic [101:0] mem_to_wb_bus;
  logic dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_rsp_valid, mem_load_pending;
  logic [31:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata, dmem_rsp_rdata;
  logic [7:0]  dmem_req_wmask;
  logic [4:0]  mem_rd;

  always #5 clk = ~clk;

  ysyx_22040127_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin), .ex_to_mem_bus(ex_to_mem_bus),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin), .mem_to_wb_bus(mem_to_wb_bus),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_wen(dmem_req_wen),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .mem_rd(mem_rd), .mem_load_pending(mem_load_pending)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  memop;
    logic        jalr, reg_wen, memwrite, memread;
    logic [4:0]  rd;
    logic [63:0] alu_out, wdata;
  } instr_t;

  typedef struct {
    logic [101:0] bus;
    logic [101:0] care;
    logic [4:0]   rd_view;
    int           exp_lat;
    int           latch_cyc;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_exp_t;

  instr_t   issue_q[$];
  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 1, wb_mode = 1, rsp_dly_mode = 0, gap_mode = 0, lat_check = 0;
  int hs_count = 0, last_hold = 0;
  bit rsp_hold = 0;
  bit head_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backing store contents; one word is pinned so the sign-extension case is known.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0000_8000_0000;
    return {a ^ 32'h5A5A_C3C3, a * 32'd2654435761};
  endfunction

  function automatic logic [63:0] load_model(input logic [2:0] op, input logic [63:0] word,
                                             input logic [2:0] off);
    logic [63:0] b, v;
    b = word >> (8 * off);
    case (op)
      3'd0: begin v = b & 64'hFF;        if (v >= 64'h80)        v = v - 64'h100; end
      3'd1: begin v = b & 64'hFFFF;      if (v >= 64'h8000)      v = v - 64'h1_0000; end
      3'd2: begin v = b & 64'hFFFF_FFFF; if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000; end
      3'd3: v = b;
      3'd4: v = b & 64'hFF;
      3'd5: v = b & 64'hFFFF;
      3'd6: v = b & 64'hFFFF_FFFF;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  function automatic logic [171:0] pack(input instr_t i);
    return {i.jalr, i.pc, i.memop, i.reg_wen, i.memwrite, i.memread, i.rd, i.alu_out, i.wdata};
  endfunction

  function automatic logic [171:0] rand_bus();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[171:0];
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [2:0] op, input logic wen,
                                input logic mw, input logic mr, input logic [4:0] rd,
                                input logic [63:0] alu, input logic [63:0] wd);
    instr_t i;
    i.pc = pc; i.memop = op; i.jalr = 1'b0; i.reg_wen = wen; i.memwrite = mw; i.memread = mr;
    i.rd = rd; i.alu_out = alu; i.wdata = wd;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = int'($urandom_range(0, 2));
    i.pc = $urandom; i.jalr = 1'($urandom_range(0, 1)); i.memop = 3'($urandom_range(0, 7));
    i.reg_wen = 1'($urandom_range(0, 1)); i.rd = 5'($urandom_range(0, 31));
    i.alu_out = {$urandom, $urandom}; i.wdata = {$urandom, $urandom};
    i.memread = (k == 1); i.memwrite = (k == 2);
    if (k != 0) i.alu_out[31:0] = {16'h8000, 16'($urandom)};
    return i;
  endfunction

  function automatic void expect_instr(input instr_t i, input int lat_ok, input int now);
    wb_exp_t w;
    req_exp_t r;
    logic [2:0] off;
    logic wen_eff;
    logic [63:0] res;
    logic [15:0] m;
    off = i.alu_out[2:0];
    wen_eff = i.reg_wen && !i.memwrite;
    res = i.alu_out;
    if (i.memread) res = load_model(i.memop, mem_word({i.alu_out[31:3], 3'b000}), off);
    w.bus = {i.pc, wen_eff, i.rd, res};
    w.care = i.memwrite ? {{38{1'b1}}, 64'h0} : {102{1'b1}};
    w.rd_view = wen_eff ? i.rd : 5'd0;
    w.exp_lat = (lat_ok != 0) ? ((i.memread || i.memwrite) ? 3 : 1) : -1;
    w.latch_cyc = now;
    wb_q.push_back(w);
    if (i.memread || i.memwrite) begin
      m = (16'd1 << (1 << i.memop[1:0])) - 16'd1;
      m = m << off;
      r.addr = {i.alu_out[31:3], 3'b000};
      r.wen = i.memwrite;
      r.wdata = i.wdata << (8 * off);
      r.wmask = i.memwrite ? m[7:0] : 8'h00;
      req_q.push_back(r);
    end
  endfunction

  initial begin : driver
    instr_t cur;
    bit taken;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus = '0;
    forever begin
      @(negedge clk);
      taken = !rst && ex_to_mem_valid && mem_allowin;
      if (taken) expect_instr(cur, lat_check, cyc);
      @(posedge clk); #1;
      if (taken || !ex_to_mem_valid) begin
        if (issue_q.size() > 0 && !rst && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
          cur = issue_q.pop_front();
          ex_to_mem_valid = 1'b1;
          ex_to_mem_bus = pack(cur);
        end else begin
          ex_to_mem_valid = 1'b0;
          ex_to_mem_bus = rand_bus();
        end
      end
    end
  end

  initial begin : responder
    req_exp_t r;
    bit pend;
    int dly, hold_cnt;
    logic [31:0] paddr;
    pend = 0; dly = 0; hold_cnt = 0; paddr = '0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && dmem_req_valid) begin
        hold_cnt++;
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_spurious: got request addr %h, want none", dmem_req_addr);
        end else begin
          r = req_q[0];
          chk("req_addr", 128'(dmem_req_addr), 128'(r.addr));
          chk("req_wen", 128'(dmem_req_wen), 128'(r.wen));
          chk("req_wmask", 128'(dmem_req_wmask), 128'(r.wmask));
          if (r.wen) chk("req_wdata", 128'(dmem_req_wdata), 128'(r.wdata));
          chk("load_pending_req", 128'(mem_load_pending), 128'(!r.wen));
          if (dmem_req_ready) begin
            void'(req_q.pop_front());
            pend = 1;
            dly = (rsp_dly_mode < 0) ? int'($urandom_range(0, 3)) : rsp_dly_mode;
            paddr = r.addr;
            hs_count++;
            last_hold = hold_cnt;
            hold_cnt = 0;
          end
        end
      end
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = {$urandom, $urandom};
      if (pend && !rsp_hold) begin
        if (dly == 0) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = mem_word(paddr);
          pend = 0;
        end else dly--;
      end
      dmem_req_ready = (rdy_mode < 0) ? ($urandom_range(0, 1) == 1) : (rdy_mode != 0);
    end
  end

  initial begin : monitor
    wb_exp_t e;
    wb_allowin = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && mem_to_wb_valid) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_spurious: got valid bus %h, want no valid", mem_to_wb_bus);
        end else begin
          e = wb_q[0];
          chk("wb_bus", 128'(mem_to_wb_bus & e.care), 128'(e.bus & e.care));
          chk("mem_rd", 128'(mem_rd), 128'(e.rd_view));
          chk("load_pending_done", 128'(mem_load_pending), 128'(1'b0));
          if (!head_seen && e.exp_lat >= 0)
            chk("latency", 128'(cyc - e.latch_cyc), 128'(e.exp_lat));
          head_seen = 1;
          if (!wb_allowin) chk("allowin_stalled", 128'(mem_allowin), 128'(1'b0));
          else begin
            void'(wb_q.pop_front());
            head_seen = 0;
            $display("wb pc=%h wen=%0d rd=%0d result=%h", mem_to_wb_bus[101:70],
                     mem_to_wb_bus[69], mem_to_wb_bus[68:64], mem_to_wb_bus[63:0]);
          end
        end
      end
      @(posedge clk); #1;
      wb_allowin = (wb_mode < 0) ? ($urandom_range(0, 3) != 0) : (wb_mode != 0);
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((issue_q.size() != 0 || wb_q.size() != 0 || req_q.size() != 0 || ex_to_mem_valid)
           && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (issue_q.size() != 0 || wb_q.size() != 0 || req_q.size() != 0 || ex_to_mem_valid) begin
      bad++;
      $display("FAIL drain: got %0d wb / %0d req outstanding after %0d cycles, want 0",
               wb_q.size(), req_q.size(), budget);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_allowin"}, 128'(mem_allowin), 128'(1'b1));
    chk({tag, "_wb_valid"}, 128'(mem_to_wb_valid), 128'(1'b0));
    chk({tag, "_req_valid"}, 128'(dmem_req_valid), 128'(1'b0));
    chk({tag, "_mem_rd"}, 128'(mem_rd), 128'(5'd0));
    chk({tag, "_load_pending"}, 128'(mem_load_pending), 128'(1'b0));
  endtask

  initial begin : main
    int n, h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Directed: addi, lb/lbu sign handling, sh lane placement, with exact latencies.
    lat_check = 1;
    issue_q.push_back(mk(32'h8000_0000, 3'd0, 1'b1, 1'b0, 1'b0, 5'd3, 64'h5, 64'h0));
    issue_q.push_back(mk(32'h8000_0004, 3'd0, 1'b1, 1'b0, 1'b1, 5'd5, 64'h8000_0003, 64'h0));
    issue_q.push_back(mk(32'h8000_0008, 3'd4, 1'b1, 1'b0, 1'b1, 5'd6, 64'h8000_0003, 64'h0));
    issue_q.push_back(mk(32'h8000_000C, 3'd1, 1'b1, 1'b1, 1'b0, 5'd7, 64'h8000_0006, 64'hBEEF));
    wait_idle(200);
    lat_check = 0;

    // Request held under back-pressure: ready low for four cycles.
    rdy_mode = 0;
    issue_q.push_back(mk(32'h8000_0010, 3'd3, 1'b1, 1'b0, 1'b1, 5'd9, 64'h8000_0120, 64'h0));
    n = 0;
    while (!dmem_req_valid && n < 20) begin @(negedge clk); #1; n++; end
    repeat (3) @(negedge clk);
    rdy_mode = 1;
    wait_idle(200);
    chk("req_hold_cycles", 128'(last_hold), 128'(5));

    // Writeback stall while DONE with the next instruction waiting upstream.
    wb_mode = 0;
    issue_q.push_back(mk(32'h8000_0014, 3'd2, 1'b1, 1'b0, 1'b1, 5'd10, 64'h8000_0204, 64'h0));
    issue_q.push_back(mk(32'h8000_0018, 3'd0, 1'b1, 1'b0, 1'b0, 5'd11, 64'h1234, 64'h0));
    n = 0;
    while (!mem_to_wb_valid && n < 20) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk);
    wb_mode = 1;
    wait_idle(200);

    // Reset while waiting for a load response; the late response must be ignored.
    rsp_hold = 1;
    h0 = hs_count;
    issue_q.push_back(mk(32'h8000_001C, 3'd3, 1'b1, 1'b0, 1'b1, 5'd12, 64'h8000_0300, 64'h0));
    n = 0;
    while (hs_count == h0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("reset_test_handshake", 128'(hs_count - h0), 128'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    wb_q.delete();
    head_seen = 0;
    @(negedge clk); #1;
    check_quiet("midrst");
    @(posedge clk); #2;
    rst = 1'b0;
    rsp_hold = 0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("postrst_wb_valid", 128'(mem_to_wb_valid), 128'(1'b0));
      chk("postrst_req_valid", 128'(dmem_req_valid), 128'(1'b0));
    end

    // Randomized traffic with random back-pressure on every interface.
    rdy_mode = -1; wb_mode = -1; rsp_dly_mode = -1; gap_mode = 1;
    for (int i = 0; i < 400; i++) issue_q.push_back(rand_instr());
    wait_idle(30000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
